// File: rtl/cfg_bank_bl_wl_writer_pkg.sv
// Shared types and sizing helpers for the BL/WL configuration bank writer.
package cfg_bank_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SETUP = 3'd2,
        PULSE = 3'd3,
        HOLD  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int unsigned TMR_W = 4;

    // Number of din beats needed to fill one bl word.
    function automatic int unsigned beats_f(input int unsigned bl_w, input int unsigned din_w);
        return (bl_w + din_w - 1) / din_w;
    endfunction

    // Counter width for n states, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cfg_bank_bl_wl_writer_if.sv
// Valid/ready bitstream stream feeding the bank writer.
interface cfg_bank_bl_wl_writer_if #(
    parameter int unsigned DIN_WIDTH = 8
) ();
    logic [DIN_WIDTH-1:0] din;
    logic                 din_valid;
    logic                 din_ready;

    modport master (output din, output din_valid, input  din_ready);
    modport slave  (input  din, input  din_valid, output din_ready);
endinterface

// File: rtl/cfg_bank_bl_wl_writer_phase_timer.sv
// Loadable down-counter shared by the SETUP, PULSE and HOLD phases.
module cfg_bank_phase_timer
    import cfg_bank_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    output logic             expire_c
);
    logic [TMR_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TMR_W'(1);
        end
    end

    // Last cycle of the loaded phase.
    assign expire_c = (cnt == TMR_W'(1));

endmodule

// File: rtl/cfg_bank_bl_wl_writer.sv
// Packs a streamed bitstream into bl words and strobes one wl row per word.
module cfg_bank_bl_wl_writer
    import cfg_bank_pkg::*;
#(
    parameter int unsigned BL_WIDTH  = 72,
    parameter int unsigned WL_WIDTH  = 72,
    parameter int unsigned DIN_WIDTH = 8,
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic                         prog_clk,
    input  logic                         prog_reset_n,
    input  logic                         start,
    cfg_bank_bl_wl_writer_if.slave       in_if,
    output logic [BL_WIDTH-1:0]          bl,
    output logic [WL_WIDTH-1:0]          wl,
    output logic                         busy,
    output logic                         done,
    output logic [cnt_w(WL_WIDTH)-1:0]   row_idx
);
    localparam int unsigned BEATS     = beats_f(BL_WIDTH, DIN_WIDTH);
    localparam int unsigned BW        = cnt_w(BEATS);
    localparam int unsigned RW        = cnt_w(WL_WIDTH);
    localparam int unsigned LAST_BEAT = BEATS - 1;
    localparam int unsigned LAST_ROW  = WL_WIDTH - 1;

    state_t            state, state_nxt;
    logic [BW-1:0]     beat_cnt, beat_nxt;
    logic [RW-1:0]     row_nxt;
    logic [BL_WIDTH-1:0] bl_nxt;
    logic [WL_WIDTH-1:0] wl_nxt;
    logic              busy_nxt, done_nxt;
    logic              rdy, rdy_nxt;
    logic              hs;
    logic              tmr_load;
    logic [TMR_W-1:0]  tmr_val;
    logic              expire_c;

    assign hs              = rdy & in_if.din_valid;
    assign in_if.din_ready = rdy;

    cfg_bank_phase_timer u_timer (
        .clk      (prog_clk),
        .rst_n    (prog_reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire_c (expire_c)
    );

    // Beat steering: each bl bit takes its din bit on the matching beat; overflow bits of the last beat fall away.
    for (genvar i = 0; i < BEATS; i++) begin : g_beat
        for (genvar j = 0; j < DIN_WIDTH; j++) begin : g_bit
            if (i * DIN_WIDTH + j < BL_WIDTH) begin : g_used
                assign bl_nxt[i*DIN_WIDTH+j] = (hs && beat_cnt == BW'(i)) ? in_if.din[j]
                                                                           : bl[i*DIN_WIDTH+j];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        row_nxt   = row_idx;
        wl_nxt    = '0;
        busy_nxt  = busy;
        done_nxt  = done;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = LOAD;
                    row_nxt   = '0;
                    beat_nxt  = '0;
                    busy_nxt  = 1'b1;
                    done_nxt  = 1'b0;
                end
            end
            LOAD: begin
                if (hs) begin
                    if (beat_cnt == BW'(LAST_BEAT)) begin
                        state_nxt = SETUP;
                        tmr_load  = 1'b1;
                        tmr_val   = TMR_W'(SETUP_CYC);
                    end else begin
                        beat_nxt = beat_cnt + BW'(1);
                    end
                end
            end
            SETUP: begin
                if (expire_c) begin
                    state_nxt       = PULSE;
                    tmr_load        = 1'b1;
                    tmr_val         = TMR_W'(PULSE_CYC);
                    wl_nxt[row_idx] = 1'b1;
                end
            end
            PULSE: begin
                if (expire_c) begin
                    state_nxt = HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = TMR_W'(HOLD_CYC);
                end else begin
                    wl_nxt = wl;
                end
            end
            HOLD: begin
                if (expire_c) begin
                    if (row_idx == RW'(LAST_ROW)) begin
                        state_nxt = DONE;
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = LOAD;
                        row_nxt   = row_idx + RW'(1);
                        beat_nxt  = '0;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        rdy_nxt = (state_nxt == LOAD);
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state    <= IDLE;
            beat_cnt <= '0;
            row_idx  <= '0;
            bl       <= '0;
            wl       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rdy      <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat_cnt <= beat_nxt;
            row_idx  <= row_nxt;
            bl       <= bl_nxt;
            wl       <= wl_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            rdy      <= rdy_nxt;
        end
    end

endmodule
